od_serial_tx: RTL and testbench
===============================

Name: od_serial_tx

Overview:
- Open-drain serial transmitter for a shared wired net.
- The pad is wired as `(strong0, highz1)` from this block, with an external `pull1` keeper. The net idles at 1.
- The block serializes one DATA_W-bit word per frame onto the net. It reads the resolved net value back.
- If it releases the line but the readback is 0, a stronger driver won the net: the block detects lost arbitration and aborts.
- This is the driving end of the strength-resolved net; the resolving/receiving side is existing code.

Parameters:
- DATA_W, 8, payload bits per frame, sent MSB first.
- BIT_CYCLES, 4, clock cycles each bit is held on the net. Minimum 2.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- tx_valid  input  1  a word is offered on tx_data.
- tx_ready  output  1  block accepts a word this cycle.
- tx_data  input  DATA_W  word to send; sampled on accept.
- drive_low  output  1  1 = drive net strong0; 0 = release (net pulled to 1).
- net_i  input  1  resolved net value read back.
- busy  output  1  a frame is in progress.
- done  output  1  one-cycle pulse when a frame completes cleanly.
- arb_lost  output  1  one-cycle pulse when a frame aborts on lost arbitration.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE.
  - drive_low=0, busy=0, done=0, arb_lost=0.
  - Shift register and counters cleared.
  - Reset has priority over every other event, including mid-frame; the line is released the cycle after reset is sampled.
- tx_ready is combinational: (state==IDLE) && (net_i==1) && !rst. It never asserts while another driver holds the line low.
- Accept: tx_valid && tx_ready at an edge. tx_data is latched and the FSM goes to START. tx_valid without tx_ready has no effect.
- FSM states and transitions:
  - IDLE -> START on accept.
  - START: drive_low=1 for BIT_CYCLES cycles, then -> DATA with bit index DATA_W-1.
  - DATA: drive_low = ~bit[idx] for BIT_CYCLES cycles.
    - After the last data bit (idx 0), go to STOP.
    - Otherwise idx decrements.
  - STOP: drive_low=0 for BIT_CYCLES cycles, then -> IDLE.
    - done=1 in the first IDLE cycle, for exactly one cycle.
- Timing:
  - busy=1 in START, DATA and STOP; 0 in IDLE.
  - drive_low and busy are registered: they change the cycle after the state is entered-by-edge, i.e. the first START cycle is the cycle after accept.
  - Frame length: exactly (DATA_W+2)*BIT_CYCLES cycles of busy=1.
- Arbitration:
  - Applies to DATA bits whose value is 1, and to STOP.
  - net_i is sampled in the last cycle of each such bit (bit cycle counter == BIT_CYCLES-1).
  - If net_i==0 at the sample:
    - Next cycle: state=IDLE, drive_low=0, busy=0, arb_lost=1 for one cycle, done stays 0.
    - The word is discarded and not retried.
  - No check on driven-0 bits or on START.
  - net_i glitches before the sample cycle are ignored.
- A new accept may occur in the first IDLE cycle after done, or after arb_lost, provided net_i==1. Back-to-back frames are therefore separated by at least one idle cycle.
- done and arb_lost are never asserted together.

Test Plan:
- Reset values: hold rst=1 for 3 cycles with tx_valid=1 and net_i=1 -> tx_ready=0, drive_low=0, busy=0, done=0, arb_lost=0. Release reset -> tx_ready=1.
- Clean frame: DATA_W=8, BIT_CYCLES=4, tx_data=0xA5, net_i modelled as resolved ~drive_low.
  - drive_low per bit: START=1, then 0,1,0,1,1,0,1,0, then STOP=0; each level held 4 cycles.
  - busy high for 40 cycles.
  - done pulses once, 1 cycle after STOP ends.
- Arbitration loss: tx_data=0xC0; external strong0 forces net_i=0 throughout data bit 6 (value 1).
  - arb_lost=1 in the cycle after bit 6's sample cycle.
  - drive_low=0 and busy=0 from that cycle on; done never asserts.
- Busy line: net_i=0 while idle with tx_valid=1 -> tx_ready=0 and no frame starts. Set net_i=1 -> accept on the next edge.
- Reset mid-frame: assert rst during DATA bit 3 while drive_low=1 -> next cycle drive_low=0, busy=0, state IDLE, and no done or arb_lost pulse.
- Back-to-back: tx_valid held high with 0x00 then 0xFF -> second accept in the first IDLE cycle after done. 0xFF frame completes with done; no arb_lost.

Source files
------------

// File: rtl/od_serial_tx.sv
// od_serial_tx: open-drain serial transmitter for a wired net.
//
// The pad is wired (strong0, highz1) with an external pull1 keeper, so the
// block can only pull the net low or let go of it. Each frame is a START bit
// (net low), DATA_W payload bits MSB first, and a STOP bit (net released).
// Each bit lasts BIT_CYCLES clocks. Whenever the block lets go of the net, it
// reads the resolved value back. If the net is 0 at that point, another driver
// owns the net, so the frame is abandoned and arb_lost pulses.

module od_serial_tx #(
   parameter int DATA_W     = 8,
   parameter int BIT_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tx_valid,
   output logic              tx_ready,
   input  logic [DATA_W-1:0] tx_data,
   output logic              drive_low,
   input  logic              net_i,
   output logic              busy,
   output logic              done,
   output logic              arb_lost
);

   // BIT_CYCLES is at least 2, so CNT_W is never 0.
   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int CNT_W = $clog2(BIT_CYCLES);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_e;

   state_e            state_q,     state_d;
   logic [DATA_W-1:0] shreg_q,     shreg_d;
   logic [IDX_W-1:0]  idx_q,       idx_d;
   logic [CNT_W-1:0]  cnt_q,       cnt_d;
   logic              drive_low_q, drive_low_d;
   logic              busy_q,      busy_d;
   logic              done_q,      done_d;
   logic              arb_lost_q,  arb_lost_d;

   logic accept;
   logic bit_end;
   logic cur_bit;
   logic lost;

   // A new word is taken only when the block is idle and nobody else holds the net low.
   assign tx_ready = (state_q == S_IDLE) && net_i && !rst;
   assign accept   = tx_valid && tx_ready;

   // The last clock of the current bit is also the arbitration sample point.
   assign bit_end  = (cnt_q == CNT_LAST);
   assign cur_bit  = shreg_q[DATA_W-1];

   // Only released bits (data 1, STOP) can be overruled by another driver.
   // Glitches earlier in a bit are ignored; only the last cycle counts.
   assign lost = bit_end && !net_i &&
                 (((state_q == S_DATA) && cur_bit) || (state_q == S_STOP));

   // Next-state and next-output logic; outputs are computed for the state being entered.
   always_comb begin
      // NOTE: every *_d gets a default here, so no path leaves a value unassigned
      // and no latch is inferred.
      state_d     = state_q;
      shreg_d     = shreg_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      drive_low_d = drive_low_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      arb_lost_d  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d     = S_START;
               shreg_d     = tx_data;
               idx_d       = IDX_MSB;
               cnt_d       = '0;
               drive_low_d = 1'b1;
               busy_d      = 1'b1;
            end
         end

         S_START: begin
            if (bit_end) begin
               state_d     = S_DATA;
               idx_d       = IDX_MSB;
               cnt_d       = '0;
               drive_low_d = ~cur_bit;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_DATA: begin
            if (lost) begin
               state_d     = S_IDLE;
               shreg_d     = '0;
               idx_d       = '0;
               cnt_d       = '0;
               drive_low_d = 1'b0;
               busy_d      = 1'b0;
               arb_lost_d  = 1'b1;
            end else if (bit_end) begin
               cnt_d = '0;
               if (idx_q == '0) begin
                  state_d     = S_STOP;
                  drive_low_d = 1'b0;
               end else begin
                  idx_d       = idx_q - 1'b1;
                  shreg_d     = shreg_q << 1;
                  drive_low_d = ~shreg_d[DATA_W-1];
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_STOP: begin
            if (lost) begin
               state_d     = S_IDLE;
               shreg_d     = '0;
               idx_d       = '0;
               cnt_d       = '0;
               drive_low_d = 1'b0;
               busy_d      = 1'b0;
               arb_lost_d  = 1'b1;
            end else if (bit_end) begin
               state_d     = S_IDLE;
               shreg_d     = '0;
               idx_d       = '0;
               cnt_d       = '0;
               drive_low_d = 1'b0;
               busy_d      = 1'b0;
               done_d      = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d     = S_IDLE;
            drive_low_d = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   // State register with synchronous reset; reset wins over any frame in flight.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every flop
      // samples the values from before the edge.
      if (rst) begin
         state_q     <= S_IDLE;
         // NOTE: the shift register is a few flops rather than a memory, and it is
         // cleared explicitly so a frame that was interrupted leaves no residue.
         shreg_q     <= '0;
         idx_q       <= '0;
         cnt_q       <= '0;
         drive_low_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         arb_lost_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         drive_low_q <= drive_low_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         arb_lost_q  <= arb_lost_d;
      end
   end

   assign drive_low = drive_low_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign arb_lost  = arb_lost_q;

endmodule

// File: tb/tb_od_serial_tx.sv
// Testbench for od_serial_tx: the net is modelled as a wired-AND of this block
// and one external open-drain driver (ext_low). A scoreboard holds the expected
// outcome (clean or lost, busy length) of every frame the bench starts.

module tb_od_serial_tx;

   localparam int DW = 8;
   localparam int BC = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          tx_valid;
   logic          tx_ready;
   logic [DW-1:0] tx_data;
   logic          drive_low;
   logic          net_i;
   logic          busy;
   logic          done;
   logic          arb_lost;
   logic          ext_low;

   int tests_run    = 0;
   int tests_failed = 0;

   // Resolved net: low if either driver pulls it down, otherwise the keeper holds it at 1.
   assign net_i = !(drive_low || ext_low);

   od_serial_tx #(
      .DATA_W     (DW),
      .BIT_CYCLES (BC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .tx_data   (tx_data),
      .drive_low (drive_low),
      .net_i     (net_i),
      .busy      (busy),
      .done      (done),
      .arb_lost  (arb_lost)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit exp_arb;
      int exp_len;
   } exp_t;

   typedef struct {
      logic [DW-1:0] data;
      int            ext_from;  // first busy cycle with ext_low=1 (-1: none)
      int            ext_to;    // first busy cycle after the window
      bit            exp_arb;
      int            exp_len;   // busy cycles expected
   } vec_t;

   exp_t sb[$];
   exp_t mon_e;
   int   busy_run = 0;
   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected drive_low level in busy cycle j of a clean frame.
   function automatic logic model_drive(input logic [DW-1:0] d, input int j);
      int seg;
      seg = j / BC;
      if (seg == 0) return 1'b1;
      if (seg <= DW) return ~d[DW - seg];
      return 1'b0;
   endfunction

   // Scoreboard consumer: each done/arb_lost pulse is matched to the oldest expected frame.
   always @(negedge clk) begin
      if (done || arb_lost) begin
         check("done_arb_exclusive", done && arb_lost, 1'b0);
         if (sb.size() == 0) begin
            check("unexpected_pulse", {done, arb_lost}, 2'b00);
         end else begin
            mon_e = sb.pop_front();
            check("pulse_kind_arb", arb_lost, mon_e.exp_arb);
            check("frame_busy_len", busy_run, mon_e.exp_len);
         end
         busy_run = 0;
      end else if (busy) begin
         busy_run++;
      end else begin
         busy_run = 0;
      end
   end

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (tx_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) check("ready_timeout", 1'b0, 1'b1);
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (sb.size() == 0 && busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("idle_timeout", 1'b0, 1'b1);
   endtask

   // One table vector: start a frame, drive the external window, check every busy cycle.
   task automatic run_vec(input vec_t v);
      bit ok;
      exp_t e;
      wait_ready(ok);
      if (!ok) return;
      tx_valid = 1'b1;
      tx_data  = v.data;
      e.exp_arb = v.exp_arb;
      e.exp_len = v.exp_len;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      tx_valid = 1'b0;
      for (int j = 0; j <= v.exp_len; j++) begin
         ext_low = (j >= v.ext_from) && (j < v.ext_to);
         if (j < v.exp_len) begin
            check($sformatf("vec_%02h_drive_c%0d", v.data, j), drive_low, model_drive(v.data, j));
            check($sformatf("vec_%02h_busy_c%0d", v.data, j), busy, 1'b1);
         end else begin
            check($sformatf("vec_%02h_busy_end", v.data), busy, 1'b0);
            check($sformatf("vec_%02h_drive_end", v.data), drive_low, 1'b0);
         end
         @(negedge clk);
      end
      ext_low = 1'b0;
   endtask

   initial begin
      bit   ok;
      exp_t e;

      rst      = 1'b1;
      tx_valid = 1'b1;
      tx_data  = 8'h55;
      ext_low  = 1'b0;

      // Table: data, external window, expected arbitration result and busy length.
      vecs[0] = '{8'hA5, -1, -1, 1'b0, 40};  // clean frame
      vecs[1] = '{8'hC0,  8, 12, 1'b1, 12};  // bit 6 (value 1) overruled
      vecs[2] = '{8'h00, 12, 16, 1'b0, 40};  // external low on a driven-0 bit: no check
      vecs[3] = '{8'hFF,  0,  4, 1'b0, 40};  // external low during START: no check
      vecs[4] = '{8'h81,  4,  7, 1'b0, 40};  // glitch before bit 7 sample: ignored
      vecs[5] = '{8'h5A, 36, 40, 1'b1, 40};  // overruled in STOP
      vecs[6] = '{8'h01, 35, 36, 1'b1, 36};  // low only at bit 0 sample cycle

      // Reset values with tx_valid and an idle net.
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("rst_tx_ready", tx_ready, 1'b0);
         check("rst_drive_low", drive_low, 1'b0);
         check("rst_busy", busy, 1'b0);
         check("rst_done", done, 1'b0);
         check("rst_arb_lost", arb_lost, 1'b0);
      end
      rst      = 1'b0;
      tx_valid = 1'b0;
      #1;
      check("post_rst_tx_ready", tx_ready, 1'b1);
      @(negedge clk);

      // Table-driven frames.
      for (int i = 0; i < 7; i++) begin
         run_vec(vecs[i]);
      end
      wait_idle();

      // Busy line: another driver holds the net low, so nothing is accepted.
      ext_low  = 1'b1;
      tx_valid = 1'b1;
      tx_data  = 8'h3C;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("busyline_tx_ready", tx_ready, 1'b0);
         check("busyline_no_start", busy, 1'b0);
      end
      ext_low = 1'b0;
      #1;
      check("busyline_ready_after_release", tx_ready, 1'b1);
      e.exp_arb = 1'b0;
      e.exp_len = 40;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      check("busyline_accept", busy, 1'b1);
      tx_valid = 1'b0;
      wait_idle();

      // Reset in the middle of data bit 3 while it is driven low.
      wait_ready(ok);
      if (ok) begin
         tx_valid = 1'b1;
         tx_data  = 8'hF0;
         @(posedge clk);
         @(negedge clk);
         tx_valid = 1'b0;
         repeat (21) @(negedge clk);
         check("midrst_drive_before", drive_low, 1'b1);
         rst = 1'b1;
         @(negedge clk);
         check("midrst_drive_low", drive_low, 1'b0);
         check("midrst_busy", busy, 1'b0);
         check("midrst_done", done, 1'b0);
         check("midrst_arb_lost", arb_lost, 1'b0);
         rst = 1'b0;
         repeat (3) @(negedge clk);
         check("midrst_idle_ready", tx_ready, 1'b1);
         check("midrst_still_idle", busy, 1'b0);
      end

      // Back-to-back: tx_valid held, second word accepted in the done cycle.
      wait_ready(ok);
      if (ok) begin
         tx_valid  = 1'b1;
         tx_data   = 8'h00;
         e.exp_arb = 1'b0;
         e.exp_len = 40;
         sb.push_back(e);
         @(posedge clk);
         @(negedge clk);
         ok = 1'b0;
         for (int k = 0; k < 60; k++) begin
            if (done === 1'b1) begin
               ok = 1'b1;
               break;
            end
            @(negedge clk);
         end
         check("b2b_done_seen", ok, 1'b1);
         check("b2b_ready_in_done_cycle", tx_ready, 1'b1);
         tx_data = 8'hFF;
         sb.push_back(e);
         @(posedge clk);
         @(negedge clk);
         check("b2b_second_accept", busy, 1'b1);
         check("b2b_second_start_drive", drive_low, 1'b1);
         tx_valid = 1'b0;
         wait_idle();
      end

      repeat (5) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Hard stop if something stalls beyond every bounded wait.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

endmodule
